serial_adder: RTL and testbench

- Bit-serial two-operand adder.
- Parallel-loads two WIDTH-bit operands, then emits their sum one bit per clock, LSB first, on a single serial output.
- Uses a stored carry between bits.
- Sits between a parallel operand source and a serial consumer. It also provides a parallel copy of the result and the final carry-out when done.

---
 rtl/serial_adder_if.sv | 36 +++
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Operand/result bundle for the bit-serial adder.
//   master : operand source and result consumer (drives mode, a, b)
//   slave  : the adder itself (drives sum, sum_valid, done, cout, result)
//
//   mode      1 = load operands, 0 = add/shift one bit per clock
//   a, b      WIDTH-bit operands, sampled only on load
//   sum       registered serial sum bit, LSB first
//   sum_valid high for the cycle in which sum holds a valid bit
//   done      high once all WIDTH bits are produced; held until next load
//   cout      final carry-out, valid while done=1
//   result    parallel copy of the sum, valid while done=1
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sum;
  logic             sum_valid;
  logic             done;
  logic             cout;
  logic [WIDTH-1:0] result;

  modport master (
    output mode, a, b,
    input  sum, sum_valid, done, cout, result
  );

  modport slave (
    input  mode, a, b,
    output sum, sum_valid, done, cout, result
  );
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial two-operand adder. Loads two WIDTH-bit operands in parallel,
//   then produces their sum one bit per clock, LSB first, carrying between
//   bits in a single flop. After WIDTH add steps the parallel result and the
//   final carry-out are presented alongside a sticky done flag.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset; clears every register
//   bus    serial_adder_if.slave (mode/a/b in; sum/sum_valid/done/cout/result out)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;

  // Full-adder on the current LSBs and the stored carry.
  logic sum_bit;
  logic carry_new;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_new = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through this block leaves it unassigned (which would infer a latch).
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    done_d      = done_q;
    cout_d      = cout_q;

    if (bus.mode) begin
      // Load always wins over an addition in progress and restarts it.
      a_d         = bus.a;
      b_d         = bus.b;
      result_d    = '0;
      cnt_d       = '0;
      carry_d     = 1'b0;
      sum_d       = 1'b0;
      sum_valid_d = 1'b0;
      done_d      = 1'b0;
      cout_d      = 1'b0;
    end else if (cnt_q < CNT_END) begin
      a_d         = {1'b0, a_q[WIDTH-1:1]};
      b_d         = {1'b0, b_q[WIDTH-1:1]};
      result_d    = {sum_bit, result_q[WIDTH-1:1]};
      cnt_d       = cnt_q + 1'b1;
      carry_d     = carry_new;
      sum_d       = sum_bit;
      sum_valid_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
        cout_d = carry_new;
      end
    end else begin
      // Idle after completion: done/cout/result stay put, serial output quiet.
      sum_d       = 1'b0;
      sum_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.done      = done_q;
  assign bus.cout      = cout_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder (WIDTH=16). Inputs change 1 ns after each
//   rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sum"},       32'(bus.sum),       32'h0);
    check({tag, ".sum_valid"}, 32'(bus.sum_valid), 32'h0);
    check({tag, ".done"},      32'(bus.done),      32'h0);
    check({tag, ".cout"},      32'(bus.cout),      32'h0);
    check({tag, ".result"},    32'(bus.result),    32'h0);
  endtask

  task automatic load(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    bus.mode = 1'b1;
    bus.a    = av;
    bus.b    = bv;
    @(posedge clk);
    #1;
    check("load.sum_valid", 32'(bus.sum_valid), 32'h0);
    check("load.done",      32'(bus.done),      32'h0);
    bus.mode = 1'b0;
  endtask

  // n add cycles; exp_bits holds the hand-computed sum, serial bit i = exp_bits[i].
  task automatic add_cycles(input string tag, input int n,
                            input logic [WIDTH-1:0] exp_bits);
    for (int i = 0; i < n; i++) begin
      bus.mode = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".sum"},       32'(bus.sum),       32'(exp_bits[i]));
      check({tag, ".sum_valid"}, 32'(bus.sum_valid), 32'h1);
      check({tag, ".done"},      32'(bus.done),      32'(i == WIDTH - 1));
    end
  endtask

  task automatic check_final(input string tag, input logic [WIDTH-1:0] exp_res,
                             input logic exp_cout);
    check({tag, ".result"}, 32'(bus.result), 32'(exp_res));
    check({tag, ".cout"},   32'(bus.cout),   32'(exp_cout));
    check({tag, ".done"},   32'(bus.done),   32'h1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    bus.mode = 1'b1;
    bus.a    = '0;
    bus.b    = '0;

    // Reset state
    #1;
    check_all_zero("reset");
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic add: 8888 + 1111 = 9999, serial 1,0,0,1 x4
    load(16'h8888, 16'h1111);
    add_cycles("basic", WIDTH, 16'h9999);
    check_final("basic", 16'h9999, 1'b0);

    // Idle after done: five extra cycles, everything holds
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle.sum_valid", 32'(bus.sum_valid), 32'h0);
      check("idle.sum",       32'(bus.sum),       32'h0);
      check_final("idle", 16'h9999, 1'b0);
    end

    // Overflow: FFFF + 0001 = 1_0000
    load(16'hFFFF, 16'h0001);
    add_cycles("ovf", WIDTH, 16'h0000);
    check_final("ovf", 16'h0000, 1'b1);

    // Full carry chain: FFFF + FFFF = 1_FFFE
    load(16'hFFFF, 16'hFFFF);
    add_cycles("chain", WIDTH, 16'hFFFE);
    check_final("chain", 16'hFFFE, 1'b1);

    // Reload mid-operation: 00FF+0001 partial (bits of 0100), then 3+5 = 8
    load(16'h00FF, 16'h0001);
    add_cycles("part", 5, 16'h0100);
    load(16'h0003, 16'h0005);
    add_cycles("reload", WIDTH, 16'h0008);
    check_final("reload", 16'h0008, 1'b0);

    // Async reset during bit 7 of 00FF+0001 (carry is live through bit 7)
    load(16'h00FF, 16'h0001);
    add_cycles("pre_rst", 7, 16'h0100);
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1 reset = 1'b1;
    // No load after reset: adds zeros, must not revive the old carry
    add_cycles("post_rst", WIDTH, 16'h0000);
    check_final("post_rst", 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
